// File: rtl/plru_set_array.sv
// Tree-PLRU replacement state for every cache set: touches, victim queries with
// invalid-way priority, and a sweep clear. Define PLRU_STATS_EN for activity counters.
`timescale 1ns/1ps

module plru_set_array #(
  parameter  int N_WAY  = 16,
  parameter  int N_SETS = 1024,
  localparam int WAY_W  = $clog2(N_WAY),
  localparam int SET_W  = $clog2(N_SETS)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             req_ready,
  input  logic             tch_valid,
  input  logic [SET_W-1:0] tch_set,
  input  logic [WAY_W-1:0] tch_way,
  input  logic             vic_valid,
  input  logic [SET_W-1:0] vic_set,
  input  logic [N_WAY-1:0] vic_inv_mask,
  input  logic             vic_fill,
  output logic             vic_rsp_valid,
  output logic [WAY_W-1:0] vic_way,
  output logic             vic_from_inv,
`ifdef PLRU_STATS_EN
  output logic [31:0]      stat_touch,
  output logic [31:0]      stat_tree_vic,
`endif
  input  logic             clr_start,
  output logic             busy
);

  localparam int               NODES    = N_WAY - 1;
  localparam logic [SET_W-1:0] LAST_SET = SET_W'(N_SETS - 1);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  state_e           state_q, state_d;
  logic [SET_W-1:0] cnt_q, cnt_d;
  logic             clr_we;

  logic [NODES-1:0] tree_q [N_SETS];

  logic             idle;
  logic             clr_acc;
  logic             tch_we;
  logic             vic_acc;
  logic             fill_we;
  logic             vic_any_inv;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] vic_pick;
  logic [NODES-1:0] vic_old;
  logic [NODES-1:0] tch_old;
  logic [NODES-1:0] tch_new;
  logic [NODES-1:0] fill_base;
  logic [NODES-1:0] fill_new;

  logic             vic_rsp_valid_q;
  logic [WAY_W-1:0] vic_way_q;
  logic             vic_from_inv_q;

  // Level l holds nodes 2^l-1 .. 2^(l+1)-2; the node on the path is picked by the
  // way's top l bits, so every index is a constant after unrolling.
  function automatic logic [NODES-1:0] touch_path(input logic [NODES-1:0] s,
                                                  input logic [WAY_W-1:0] w);
    logic [NODES-1:0] r;
    r = s;
    for (int l = 0; l < WAY_W; l++) begin
      for (int j = 0; j < (1 << l); j++) begin
        if ((w >> (WAY_W - l)) == WAY_W'(j)) begin
          r[(1 << l) - 1 + j] = w[WAY_W-1-l];
        end
      end
    end
    return r;
  endfunction

  function automatic logic [WAY_W-1:0] tree_victim(input logic [NODES-1:0] s);
    logic [WAY_W-1:0] w;
    w = '0;
    for (int l = 0; l < WAY_W; l++) begin
      for (int j = 0; j < (1 << l); j++) begin
        if ((w >> (WAY_W - l)) == WAY_W'(j)) begin
          w[WAY_W-1-l] = ~s[(1 << l) - 1 + j];
        end
      end
    end
    return w;
  endfunction

  assign idle      = (state_q == ST_IDLE);
  assign req_ready = idle;
  assign busy      = ~idle;

  // A clear request claims its cycle; touches and queries alongside it are dropped.
  assign clr_acc = idle & clr_start;
  assign tch_we  = idle & ~clr_start & tch_valid;
  assign vic_acc = idle & ~clr_start & vic_valid;
  assign fill_we = vic_acc & vic_fill;

  assign vic_any_inv = |vic_inv_mask;

  always_comb begin
    inv_way = '0;
    for (int i = N_WAY - 1; i >= 0; i--) begin
      if (vic_inv_mask[i]) begin
        inv_way = WAY_W'(i);
      end
    end
  end

  assign vic_old  = tree_q[vic_set];
  assign tch_old  = tree_q[tch_set];
  assign vic_pick = vic_any_inv ? inv_way : tree_victim(vic_old);
  assign tch_new  = touch_path(tch_old, tch_way);

  // The victim is chosen from pre-touch state, but a same-set fill is layered on
  // top of the touch so shared nodes end up holding the fill's values.
  assign fill_base = (tch_we && (tch_set == vic_set)) ? tch_new : vic_old;
  assign fill_new  = touch_path(fill_base, vic_pick);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_SET) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sweep writes and request writes never coincide: requests are only taken in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SETS; i++) begin
        tree_q[i] <= '0;
      end
    end else begin
      if (clr_we) begin
        tree_q[cnt_q] <= '0;
      end
      if (tch_we) begin
        tree_q[tch_set] <= tch_new;
      end
      if (fill_we) begin
        tree_q[vic_set] <= fill_new;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vic_rsp_valid_q <= 1'b0;
      vic_way_q       <= '0;
      vic_from_inv_q  <= 1'b0;
    end else begin
      vic_rsp_valid_q <= vic_acc;
      if (vic_acc) begin
        vic_way_q      <= vic_pick;
        vic_from_inv_q <= vic_any_inv;
      end
    end
  end

  assign vic_rsp_valid = vic_rsp_valid_q;
  assign vic_way       = vic_way_q;
  assign vic_from_inv  = vic_from_inv_q;

`ifdef PLRU_STATS_EN
  logic [31:0] stat_touch_q;
  logic [31:0] stat_tree_vic_q;
  logic [1:0]  touch_inc;
  logic [32:0] touch_sum;

  // A touch and a fill in the same cycle count as two updates.
  always_comb begin
    touch_inc = {1'b0, tch_we} + {1'b0, fill_we};
    touch_sum = {1'b0, stat_touch_q} + {31'b0, touch_inc};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_touch_q    <= '0;
      stat_tree_vic_q <= '0;
    end else if (clr_acc) begin
      stat_touch_q    <= '0;
      stat_tree_vic_q <= '0;
    end else begin
      stat_touch_q <= touch_sum[32] ? 32'hFFFF_FFFF : touch_sum[31:0];
      if (vic_acc && !vic_any_inv && (stat_tree_vic_q != 32'hFFFF_FFFF)) begin
        stat_tree_vic_q <= stat_tree_vic_q + 32'd1;
      end
    end
  end

  assign stat_touch    = stat_touch_q;
  assign stat_tree_vic = stat_tree_vic_q;
`endif

endmodule
